// File: rtl/call_stack.sv
// Circular return-address stack for the PIC16F84 core, with PIC-style wrap on overflow and underflow.
// Optional sticky error flags are built only when CALL_STACK_FLAGS_EN is defined.
module call_stack #(
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_pc,
    input  logic                  reset_n,
    input  logic                  push_enable,
    input  logic [ADDR_WIDTH-1:0] push_value,
    input  logic                  pop_enable,
    input  logic                  flags_clear,
    output logic [ADDR_WIDTH-1:0] return_value,
    output logic [PTR_WIDTH:0]    stack_level,
    output logic                  stack_empty,
    output logic                  stack_full,
    output logic                  stack_overflow,
    output logic                  stack_underflow
);

    localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]   LEVEL_ONE = (PTR_WIDTH + 1)'(1);
    localparam logic [PTR_WIDTH:0]   LEVEL_MAX = (PTR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  ptr;
    logic [PTR_WIDTH-1:0]  top_ptr;
    logic [PTR_WIDTH:0]    level;

    logic push_only;
    logic pop_only;
    logic top_replace;
    logic overflow_event;
    logic underflow_event;

    assign top_ptr      = ptr - PTR_ONE;
    assign return_value = mem[top_ptr];
    assign stack_level  = level;
    assign stack_empty  = (level == '0);
    assign stack_full   = (level == LEVEL_MAX);

    // A simultaneous push and pop on an empty stack degrades to a plain push.
    always_comb begin
        push_only       = 1'b0;
        pop_only        = 1'b0;
        top_replace     = 1'b0;
        overflow_event  = 1'b0;
        underflow_event = 1'b0;
        if (push_enable && (!pop_enable || stack_empty)) begin
            push_only = 1'b1;
        end
        if (pop_enable && !push_enable) begin
            pop_only = 1'b1;
        end
        if (push_enable && pop_enable && !stack_empty) begin
            top_replace = 1'b1;
        end
        if (push_only && stack_full) begin
            overflow_event = 1'b1;
        end
        if (pop_enable && stack_empty) begin
            underflow_event = 1'b1;
        end
    end

    always_ff @(posedge clk_pc or negedge reset_n) begin
        if (!reset_n) begin
            ptr   <= '0;
            level <= '0;
        end else if (push_only) begin
            ptr <= ptr + PTR_ONE;
            if (!stack_full) begin
                level <= level + LEVEL_ONE;
            end
        end else if (pop_only) begin
            ptr <= top_ptr;
            if (!stack_empty) begin
                level <= level - LEVEL_ONE;
            end
        end
    end

    always_ff @(posedge clk_pc or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_only) begin
            mem[ptr] <= push_value;
        end else if (top_replace) begin
            mem[top_ptr] <= push_value;
        end
    end

`ifdef CALL_STACK_FLAGS_EN
    logic overflow_flag;
    logic underflow_flag;

    // An error event in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk_pc or negedge reset_n) begin
        if (!reset_n) begin
            overflow_flag  <= 1'b0;
            underflow_flag <= 1'b0;
        end else begin
            if (overflow_event) begin
                overflow_flag <= 1'b1;
            end else if (flags_clear) begin
                overflow_flag <= 1'b0;
            end
            if (underflow_event) begin
                underflow_flag <= 1'b1;
            end else if (flags_clear) begin
                underflow_flag <= 1'b0;
            end
        end
    end

    assign stack_overflow  = overflow_flag;
    assign stack_underflow = underflow_flag;
`else
    logic unused_flag_inputs;

    assign unused_flag_inputs = flags_clear ^ overflow_event ^ underflow_event;
    assign stack_overflow     = 1'b0;
    assign stack_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: push/pop ordering, wrap, top replace, flags and asynchronous reset.
module tb_call_stack;

`ifdef CALL_STACK_FLAGS_EN
    localparam logic FLAG_ON = 1'b1;
`else
    localparam logic FLAG_ON = 1'b0;
`endif

    logic        clk_pc = 1'b0;
    logic        reset_n = 1'b0;
    logic        push_enable = 1'b0;
    logic [11:0] push_value = '0;
    logic        pop_enable = 1'b0;
    logic        flags_clear = 1'b0;
    logic [11:0] return_value;
    logic [3:0]  stack_level;
    logic        stack_empty;
    logic        stack_full;
    logic        stack_overflow;
    logic        stack_underflow;

    int n_cmp = 0;
    int n_err = 0;

    call_stack #(.DEPTH(8), .PTR_WIDTH(3), .ADDR_WIDTH(12)) dut (
        .clk_pc          (clk_pc),
        .reset_n         (reset_n),
        .push_enable     (push_enable),
        .push_value      (push_value),
        .pop_enable      (pop_enable),
        .flags_clear     (flags_clear),
        .return_value    (return_value),
        .stack_level     (stack_level),
        .stack_empty     (stack_empty),
        .stack_full      (stack_full),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    always #5 clk_pc = ~clk_pc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge with the given controls; returns 1 time unit after the edge.
    task automatic cyc(input logic push, input logic [11:0] val, input logic pop, input logic clr);
        push_enable = push;
        push_value  = val;
        pop_enable  = pop;
        flags_clear = clr;
        @(posedge clk_pc);
        #1;
        push_enable = 1'b0;
        pop_enable  = 1'b0;
        flags_clear = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk_pc);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [11:0] exp_val;

        do_reset();
        check_eq("rst_rv", return_value, 12'h000);
        check_eq("rst_level", stack_level, 4'd0);
        check_eq("rst_empty", stack_empty, 1'b1);
        check_eq("rst_full", stack_full, 1'b0);
        check_eq("rst_ovf", stack_overflow, 1'b0);
        check_eq("rst_unf", stack_underflow, 1'b0);

        // Three pushes then three pops, top visible before each pop edge
        cyc(1'b1, 12'h010, 1'b0, 1'b0);
        check_eq("p1_rv", return_value, 12'h010);
        cyc(1'b1, 12'h020, 1'b0, 1'b0);
        cyc(1'b1, 12'h030, 1'b0, 1'b0);
        check_eq("p3_rv", return_value, 12'h030);
        check_eq("p3_level", stack_level, 4'd3);
        check_eq("p3_empty", stack_empty, 1'b0);
        check_eq("pop1_rv", return_value, 12'h030);
        cyc(1'b0, 12'h000, 1'b1, 1'b0);
        check_eq("pop2_rv", return_value, 12'h020);
        cyc(1'b0, 12'h000, 1'b1, 1'b0);
        check_eq("pop3_rv", return_value, 12'h010);
        cyc(1'b0, 12'h000, 1'b1, 1'b0);
        check_eq("pops_empty", stack_empty, 1'b1);
        check_eq("pops_level", stack_level, 4'd0);
        check_eq("pops_unf", stack_underflow, 1'b0);

        // Pop on empty after reset
        do_reset();
        cyc(1'b0, 12'h000, 1'b1, 1'b0);
        check_eq("uf_unf", stack_underflow, FLAG_ON);
        check_eq("uf_level", stack_level, 4'd0);
        check_eq("uf_rv", return_value, 12'h000);
        check_eq("uf_empty", stack_empty, 1'b1);
        cyc(1'b0, 12'h000, 1'b0, 1'b1);
        check_eq("uf_clear", stack_underflow, 1'b0);

        // Nine pushes: overflow overwrites the oldest entry
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 12'h100 + 12'(i), 1'b0, 1'b0);
        end
        check_eq("of8_full", stack_full, 1'b1);
        check_eq("of8_ovf", stack_overflow, 1'b0);
        check_eq("of8_level", stack_level, 4'd8);
        cyc(1'b1, 12'h109, 1'b0, 1'b0);
        check_eq("of9_full", stack_full, 1'b1);
        check_eq("of9_ovf", stack_overflow, FLAG_ON);
        check_eq("of9_level", stack_level, 4'd8);
        check_eq("of9_rv", return_value, 12'h109);
        // Replace on a full stack must not raise overflow again after a clear
        cyc(1'b0, 12'h000, 1'b0, 1'b1);
        check_eq("of_clear", stack_overflow, 1'b0);
        check_eq("of_clear_level", stack_level, 4'd8);
        cyc(1'b1, 12'h109, 1'b1, 1'b0);
        check_eq("full_repl_ovf", stack_overflow, 1'b0);
        check_eq("full_repl_level", stack_level, 4'd8);
        for (int i = 0; i < 8; i++) begin
            exp_val = 12'h109 - 12'(i);
            check_eq($sformatf("of_pop%0d", i), return_value, exp_val);
            cyc(1'b0, 12'h000, 1'b1, 1'b0);
        end
        check_eq("of_pops_empty", stack_empty, 1'b1);
        check_eq("of_pops_unf", stack_underflow, 1'b0);
        // Leftover slot after wrap still holds 0x109, not the lost 0x101
        check_eq("of_stale_rv", return_value, 12'h109);

        // Overflow coinciding with a clear: the set wins
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 12'h200 + 12'(i), 1'b0, 1'b0);
        end
        cyc(1'b1, 12'h2AA, 1'b0, 1'b1);
        check_eq("setwins_ovf", stack_overflow, FLAG_ON);
        check_eq("setwins_rv", return_value, 12'h2AA);

        // Top replace on a non-empty stack
        do_reset();
        cyc(1'b1, 12'h040, 1'b0, 1'b0);
        cyc(1'b1, 12'h050, 1'b0, 1'b0);
        cyc(1'b1, 12'h077, 1'b1, 1'b0);
        check_eq("repl_level", stack_level, 4'd2);
        check_eq("repl_rv", return_value, 12'h077);
        check_eq("repl_unf", stack_underflow, 1'b0);
        cyc(1'b0, 12'h000, 1'b1, 1'b0);
        check_eq("repl_pop_rv", return_value, 12'h040);
        check_eq("repl_pop_level", stack_level, 4'd1);

        // Push and pop together on an empty stack act as a push
        do_reset();
        cyc(1'b1, 12'h0AA, 1'b1, 1'b0);
        check_eq("emp_pp_level", stack_level, 4'd1);
        check_eq("emp_pp_rv", return_value, 12'h0AA);
        check_eq("emp_pp_unf", stack_underflow, FLAG_ON);

        // Asynchronous reset between edges with five entries held
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 12'h300 + 12'(i), 1'b0, 1'b0);
        end
        check_eq("ar_pre_level", stack_level, 4'd5);
        check_eq("ar_pre_rv", return_value, 12'h305);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("ar_rv", return_value, 12'h000);
        check_eq("ar_level", stack_level, 4'd0);
        check_eq("ar_empty", stack_empty, 1'b1);
        check_eq("ar_full", stack_full, 1'b0);
        #1;
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
